// File: rtl/int_ctrl_if.sv
// int_ctrl_if: interrupt source, programming and request/ack signals between CPU and int_ctrl
interface int_ctrl_if #(parameter int NSRC = 4);
  logic [NSRC-1:0] irq_src;
  logic [NSRC-1:0] mask;
  logic            clr_we;
  logic [7:0]      clr_data;
  logic            int_ack;
  logic            reti;
  logic            int_req;
  logic [7:0]      status;
  modport slave (input irq_src, mask, clr_we, clr_data, int_ack, reti, output int_req, status);
  modport master (output irq_src, mask, clr_we, clr_data, int_ack, reti, input int_req, status);
endinterface

// File: rtl/int_ctrl.sv
// int_ctrl: edge-latching prioritised interrupt controller with request/ack/reti handshake
module int_ctrl #(
  parameter int NSRC = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic       clk,
  input logic       reset,
  int_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t          state_q, state_d;
  logic [NSRC-1:0] sync_q [SYNC_STAGES];
  logic [NSRC-1:0] edge_q, pending_q, pending_d, rise, eligible, ack_clr, clr_mask;
  logic [1:0]      winner, active_id_q, active_id_d;
  logic            int_req_q, in_service_q;
  logic [3:0]      pend_ext;
  always_comb begin
    rise = sync_q[SYNC_STAGES-1] & ~edge_q;
    eligible = pending_q & bus.mask;
    winner = '0;
    for (int i = NSRC - 1; i >= 0; i--) winner = eligible[i] ? 2'(i) : winner;
    clr_mask = bus.clr_we ? bus.clr_data[NSRC-1:0] : '0;
    ack_clr = '0;
    state_d = state_q;
    active_id_d = active_id_q;
    case (state_q)
      IDLE: state_d = (|eligible) ? REQ : IDLE;
      REQ: begin
        // losing every eligible source withdraws the request even if ack arrives together
        if (!(|eligible)) state_d = IDLE;
        else if (bus.int_ack) begin
          state_d = SERVICE;
          active_id_d = winner;
          ack_clr = NSRC'(1) << winner;
        end
      end
      SERVICE: state_d = bus.reti ? IDLE : SERVICE;
      default: state_d = IDLE;
    endcase
    // a fresh edge outranks both software clear and clear-by-ack
    pending_d = (pending_q & ~clr_mask & ~ack_clr) | rise;
    pend_ext = '0;
    pend_ext[NSRC-1:0] = pending_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      edge_q <= '0;
      pending_q <= '0;
      state_q <= IDLE;
      active_id_q <= '0;
      int_req_q <= 1'b0;
      in_service_q <= 1'b0;
    end else begin
      sync_q[0] <= bus.irq_src;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      edge_q <= sync_q[SYNC_STAGES-1];
      pending_q <= pending_d;
      state_q <= state_d;
      active_id_q <= active_id_d;
      int_req_q <= state_d == REQ;
      in_service_q <= state_d == SERVICE;
    end
  end
  assign bus.int_req = int_req_q;
  assign bus.status = {in_service_q, active_id_q, int_req_q, pend_ext};
endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed scenario tasks plus randomized run against a behavioural model of int_ctrl
module tb_int_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int nt = 0;
  int nf = 0;
  int_ctrl_if #(.NSRC(4)) bus ();
  int_ctrl #(.NSRC(4), .SYNC_STAGES(2)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  logic [3:0] p0, p1, p2, mpend;
  logic [1:0] mid;
  int         ms;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] bits);
    bus.irq_src = bits;
    tick();
    bus.irq_src = 4'h0;
  endtask

  task automatic chk(input string name, input logic [7:0] exp_status);
    nt++;
    if (bus.status !== exp_status) begin
      nf++;
      $display("FAIL %s status got %h expected %h", name, bus.status, exp_status);
    end
  endtask

  task automatic test_reset();
    chk("reset_initial", 8'h00);
    bus.mask = 4'hF;
    pulse(4'b0011);
    tick();
    tick();
    chk("reset_pending", 8'h03);
    tick();
    chk("reset_req", 8'h13);
    #2 reset = 1'b0;
    #1;
    chk("reset_async", 8'h00);
    nt++;
    if (bus.int_req !== 1'b0) begin
      nf++;
      $display("FAIL reset_int_req got %b expected 0", bus.int_req);
    end
    #2 reset = 1'b1;
    repeat (4) tick();
    chk("reset_after_release", 8'h00);
  endtask

  task automatic test_latency();
    bus.mask = 4'hF;
    bus.irq_src = 4'b0100;
    tick();
    tick();
    chk("lat_not_yet", 8'h00);
    tick();
    chk("lat_pending", 8'h04);
    tick();
    chk("lat_req", 8'h14);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    chk("lat_ack", 8'hC0);
    bus.reti = 1'b1;
    bus.irq_src = 4'h0;
    tick();
    bus.reti = 1'b0;
    chk("lat_reti", 8'h40);
    repeat (3) tick();
  endtask

  task automatic test_priority();
    pulse(4'b1010);
    tick();
    tick();
    chk("prio_pending", 8'h4A);
    tick();
    chk("prio_req", 8'h5A);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    chk("prio_ack1", 8'hA8);
    bus.reti = 1'b1;
    tick();
    bus.reti = 1'b0;
    chk("prio_reti", 8'h28);
    tick();
    chk("prio_rereq", 8'h38);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    chk("prio_ack2", 8'hE0);
    bus.reti = 1'b1;
    tick();
    bus.reti = 1'b0;
    chk("prio_idle", 8'h60);
  endtask

  task automatic test_masking();
    bus.mask = 4'b1110;
    pulse(4'b0001);
    tick();
    tick();
    chk("mask_pending", 8'h61);
    tick();
    chk("mask_no_req", 8'h61);
    bus.clr_we = 1'b1;
    bus.clr_data = 8'h01;
    tick();
    bus.clr_we = 1'b0;
    chk("mask_clear", 8'h60);
    pulse(4'b0100);
    tick();
    tick();
    chk("withdraw_pending", 8'h64);
    tick();
    chk("withdraw_req", 8'h74);
    bus.clr_we = 1'b1;
    bus.clr_data = 8'h04;
    tick();
    bus.clr_we = 1'b0;
    chk("withdraw_cleared", 8'h70);
    tick();
    chk("withdraw_idle", 8'h60);
  endtask

  task automatic test_collisions();
    bus.mask = 4'h0;
    pulse(4'b0010);
    tick();
    tick();
    chk("coll_pending", 8'h62);
    bus.irq_src = 4'b0010;
    tick();
    bus.irq_src = 4'h0;
    tick();
    bus.clr_we = 1'b1;
    bus.clr_data = 8'h02;
    tick();
    bus.clr_we = 1'b0;
    chk("coll_set_wins", 8'h62);
    bus.clr_we = 1'b1;
    tick();
    bus.clr_we = 1'b0;
    chk("coll_clear_alone", 8'h60);
    bus.mask = 4'hF;
    pulse(4'b0001);
    tick();
    tick();
    tick();
    chk("coll_req", 8'h71);
    bus.int_ack = 1'b1;
    bus.clr_we = 1'b1;
    bus.clr_data = 8'h01;
    tick();
    bus.int_ack = 1'b0;
    bus.clr_we = 1'b0;
    chk("coll_ack_wins", 8'h80);
    bus.reti = 1'b1;
    tick();
    bus.reti = 1'b0;
    chk("coll_reti", 8'h00);
  endtask

  task automatic test_spurious();
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    chk("spur_ack_idle", 8'h00);
    pulse(4'b1000);
    tick();
    tick();
    tick();
    chk("spur_req", 8'h18);
    bus.reti = 1'b1;
    tick();
    bus.reti = 1'b0;
    chk("spur_reti_req", 8'h18);
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
    chk("spur_ack", 8'hE0);
    bus.reti = 1'b1;
    tick();
    bus.reti = 1'b0;
    chk("spur_done", 8'h60);
  endtask

  // model: an edge seen two clocks back on the pin becomes pending at this edge
  task automatic model_step();
    logic [3:0] rise, elig, np;
    logic [1:0] win;
    int         nms;
    rise = p1 & ~p2;
    elig = mpend & bus.mask;
    win = 2'd0;
    for (int i = 3; i >= 0; i--) if (elig[i]) win = 2'(i);
    np = bus.clr_we ? (mpend & ~bus.clr_data[3:0]) : mpend;
    nms = ms;
    if (ms == 0 && elig != 0) nms = 1;
    else if (ms == 1 && elig == 0) nms = 0;
    else if (ms == 1 && bus.int_ack) begin
      nms = 2;
      mid = win;
      np[win] = 1'b0;
    end else if (ms == 2 && bus.reti) nms = 0;
    ms = nms;
    mpend = np | rise;
    p2 = p1;
    p1 = p0;
    p0 = bus.irq_src;
  endtask

  task automatic test_random();
    logic [7:0] exp_status;
    bus.irq_src = 4'h0;
    #2 reset = 1'b0;
    repeat (3) tick();
    #2 reset = 1'b1;
    tick();
    {p0, p1, p2, mpend, mid} = '0;
    ms = 0;
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 4) == 0) bus.irq_src[b] = ~bus.irq_src[b];
      if ($urandom_range(0, 9) == 0) bus.mask = 4'($urandom);
      bus.clr_we = $urandom_range(0, 9) == 0;
      bus.clr_data = 8'($urandom);
      bus.int_ack = $urandom_range(0, 3) == 0;
      bus.reti = $urandom_range(0, 6) == 0;
      model_step();
      tick();
      exp_status = {ms == 2, mid, ms == 1, mpend};
      nt++;
      if (bus.status !== exp_status || bus.int_req !== (ms == 1)) begin
        nf++;
        $display("FAIL rand cycle %0d status got %h expected %h int_req got %b", c, bus.status, exp_status, bus.int_req);
      end
    end
    {bus.int_ack, bus.reti, bus.clr_we} = '0;
  endtask

  initial begin
    bus.irq_src = 4'h0;
    bus.mask = 4'h0;
    bus.clr_we = 1'b0;
    bus.clr_data = 8'h00;
    bus.int_ack = 1'b0;
    bus.reti = 1'b0;
    #23 reset = 1'b1;
    tick();
    test_reset();
    test_latency();
    test_priority();
    test_masking();
    test_collisions();
    test_spurious();
    test_random();
    $display("[TB] %0d tests run, %0d failed", nt, nf);
    $finish;
  end
endmodule
